keynsham_timer: RTL and testbench



---
 rtl/keynsham_timer_pkg.sv | 29 ++
 rtl/keynsham_timer_channel.sv | 140 ++++++++++++++
 rtl/keynsham_timer.sv | 94 +++++++++
 tb/tb_keynsham_timer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/keynsham_timer_pkg.sv
// rtl/keynsham_timer_pkg.sv - shared register map, control bit positions and lane-merge helper
package keynsham_timer_pkg;

  typedef enum logic [1:0] {
    REG_COUNT   = 2'd0,
    REG_RELOAD  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN           = 0;
  localparam int CTRL_PERIODIC     = 1;
  localparam int CTRL_IRQ_EN       = 2;
  localparam int CTRL_PRESCALE_LSB = 8;

  localparam logic [19:0] TIMER_BASE = 20'h80002;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  bytesel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = bytesel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/keynsham_timer_channel.sv
// rtl/keynsham_timer_channel.sv - one down-counting timer channel with prescaler and expiry flag
module keynsham_timer_channel
  import keynsham_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  reg_sel_e    reg_sel_i,
  input  logic [3:0]  bytesel_i,
  input  logic [31:0] wr_val_i,
  output logic [31:0] rd_val_o,
  output logic        irq_o
);

  logic [31:0]               count_q, count_d;
  logic [31:0]               reload_q, reload_d;
  logic                      en_q, en_d;
  logic                      periodic_q, periodic_d;
  logic                      irq_en_q, irq_en_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] pc_q, pc_d;
  logic                      expired_q, expired_d;

  logic        tick;
  logic        count_wr, reload_wr, ctrl_wr, status_wr;
  logic [31:0] ctrl_rd;

  assign tick      = en_q && (pc_q == prescale_q);
  assign count_wr  = wr_en_i && (reg_sel_i == REG_COUNT);
  assign reload_wr = wr_en_i && (reg_sel_i == REG_RELOAD);
  assign ctrl_wr   = wr_en_i && (reg_sel_i == REG_CONTROL);
  assign status_wr = wr_en_i && (reg_sel_i == REG_STATUS);

  // Assemble the CONTROL view; unimplemented bits read as zero.
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_EN]       = en_q;
    ctrl_rd[CTRL_PERIODIC] = periodic_q;
    ctrl_rd[CTRL_IRQ_EN]   = irq_en_q;
    ctrl_rd[CTRL_PRESCALE_LSB +: PRESCALE_WIDTH] = prescale_q;
  end

  // Next-state: bus writes take priority over the tick's count/enable update, expiry set beats clear.
  always_comb begin
    count_d    = count_q;
    reload_d   = reload_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    pc_d       = pc_q;
    expired_d  = expired_q;

    if (!en_q || tick) begin
      pc_d = '0;
    end else begin
      pc_d = pc_q + 1'b1;
    end

    if (tick) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else begin
        count_d = periodic_q ? reload_q : 32'd0;
        if (!periodic_q) begin
          en_d = 1'b0;
        end
      end
    end

    if (status_wr && bytesel_i[0] && wr_val_i[0]) begin
      expired_d = 1'b0;
    end
    if (tick && (count_q == 32'd1)) begin
      expired_d = 1'b1;
    end

    if (count_wr) begin
      count_d = merge_lanes(count_q, wr_val_i, bytesel_i);
    end
    if (reload_wr) begin
      reload_d = merge_lanes(reload_q, wr_val_i, bytesel_i);
    end
    if (ctrl_wr) begin
      // A CONTROL write discards the tick's count update and restarts the prescaler.
      count_d = count_q;
      pc_d    = '0;
      if (bytesel_i[0]) begin
        en_d       = wr_val_i[CTRL_EN];
        periodic_d = wr_val_i[CTRL_PERIODIC];
        irq_en_d   = wr_val_i[CTRL_IRQ_EN];
      end
      for (int k = 0; k < PRESCALE_WIDTH; k++) begin
        if (bytesel_i[(CTRL_PRESCALE_LSB + k) / 8]) begin
          prescale_d[k] = wr_val_i[CTRL_PRESCALE_LSB + k];
        end
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= '0;
      reload_q   <= '0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      pc_q       <= '0;
      expired_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      reload_q   <= reload_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      pc_q       <= pc_d;
      expired_q  <= expired_d;
    end
  end

  // Register read view for the top-level mux.
  always_comb begin
    rd_val_o = '0;
    case (reg_sel_i)
      REG_COUNT:   rd_val_o = count_q;
      REG_RELOAD:  rd_val_o = reload_q;
      REG_CONTROL: rd_val_o = ctrl_rd;
      REG_STATUS:  rd_val_o = {31'd0, expired_q};
      default:     rd_val_o = '0;
    endcase
  end

  assign irq_o = expired_q & irq_en_q;

endmodule

// File: rtl/keynsham_timer.sv
// rtl/keynsham_timer.sv - bus-mapped multi-channel timer: decode, handshake and read mux
module keynsham_timer
  import keynsham_timer_pkg::*;
#(
  parameter int NUM_TIMERS     = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_access,
  input  logic                  bus_cs,
  input  logic [31:0]           bus_addr,
  input  logic [31:0]           bus_wr_val,
  input  logic                  bus_wr_en,
  input  logic [3:0]            bus_bytesel,
  output logic [31:0]           bus_data,
  output logic                  bus_ack,
  output logic                  bus_error,
  output logic [NUM_TIMERS-1:0] irq
);

  localparam logic [4:0] NUM_TIMERS_W = 5'(NUM_TIMERS);

  logic [3:0]  chan_idx;
  reg_sel_e    reg_sel;
  logic        sample;
  logic        offset_ok;
  logic [31:0] rd_vals [NUM_TIMERS];
  logic [31:0] rd_mux;
  logic        unused_addr;

  logic        ack_q, ack_d;
  logic        error_q, error_d;
  logic [31:0] data_q, data_d;

  assign chan_idx    = bus_addr[7:4];
  assign reg_sel     = reg_sel_e'(bus_addr[3:2]);
  assign sample      = bus_access & bus_cs;
  assign offset_ok   = (bus_addr[11:8] == 4'd0) && ({1'b0, chan_idx} < NUM_TIMERS_W);
  assign unused_addr = ^{bus_addr[31:12], bus_addr[1:0]};

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
    logic wr_strobe;
    assign wr_strobe = sample && offset_ok && bus_wr_en && (chan_idx == 4'(g));

    keynsham_timer_channel #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_chan (
      .clk_i     (clk),
      .rst_i     (rst),
      .wr_en_i   (wr_strobe),
      .reg_sel_i (reg_sel),
      .bytesel_i (bus_bytesel),
      .wr_val_i  (bus_wr_val),
      .rd_val_o  (rd_vals[g]),
      .irq_o     (irq[g])
    );
  end

  // Select the addressed channel's read view.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (chan_idx == 4'(i)) begin
        rd_mux = rd_vals[i];
      end
    end
  end

  // Response for the access sampled this cycle; read data only on a valid read.
  always_comb begin
    ack_d   = sample && offset_ok;
    error_d = sample && !offset_ok;
    data_d  = (sample && offset_ok && !bus_wr_en) ? rd_mux : '0;
  end

  // One-cycle registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      error_q <= 1'b0;
      data_q  <= '0;
    end else begin
      ack_q   <= ack_d;
      error_q <= error_d;
      data_q  <= data_d;
    end
  end

  assign bus_ack   = ack_q;
  assign bus_error = error_q;
  assign bus_data  = data_q;

endmodule

// File: tb/tb_keynsham_timer.sv
// tb/tb_keynsham_timer.sv - directed self-checking bench for keynsham_timer
module tb_keynsham_timer;

  localparam logic [1:0] R_COUNT = 2'd0, R_RELOAD = 2'd1, R_CONTROL = 2'd2, R_STATUS = 2'd3;

  logic        clk;
  logic        rst;
  logic        bus_access;
  logic        bus_cs;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_val;
  logic        bus_wr_en;
  logic [3:0]  bus_bytesel;
  logic [31:0] bus_data;
  logic        bus_ack;
  logic        bus_error;
  logic [3:0]  irq;

  int n_cmp = 0;
  int n_bad = 0;

  keynsham_timer #(.NUM_TIMERS(4), .PRESCALE_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_access (bus_access),
    .bus_cs     (bus_cs),
    .bus_addr   (bus_addr),
    .bus_wr_val (bus_wr_val),
    .bus_wr_en  (bus_wr_en),
    .bus_bytesel(bus_bytesel),
    .bus_data   (bus_data),
    .bus_ack    (bus_ack),
    .bus_error  (bus_error),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_addr(input int t, input logic [1:0] r);
    return 32'h80002000 | (32'(t) << 4) | (32'(r) << 2);
  endfunction

  task automatic bus_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] val,
                          input logic [3:0] be, output logic [31:0] rdata,
                          output logic ack, output logic err);
    @(negedge clk);
    bus_addr    = addr;
    bus_cs      = (addr[31:12] == 20'h80002);
    bus_wr_en   = wr;
    bus_wr_val  = val;
    bus_bytesel = be;
    bus_access  = 1'b1;
    @(posedge clk);
    #1;
    rdata = bus_data;
    ack   = bus_ack;
    err   = bus_error;
    bus_access = 1'b0;
    bus_cs     = 1'b0;
    bus_wr_en  = 1'b0;
  endtask

  task automatic wr_reg(input int t, input logic [1:0] r, input logic [31:0] val, input logic [3:0] be);
    logic [31:0] d;
    logic a, e;
    bus_xfer(reg_addr(t, r), 1'b1, val, be, d, a, e);
    chk("wr_ack", {31'd0, a}, 32'd1);
  endtask

  task automatic rd_reg(input int t, input logic [1:0] r, output logic [31:0] d);
    logic a, e;
    bus_xfer(reg_addr(t, r), 1'b0, 32'd0, 4'hf, d, a, e);
    chk("rd_ack", {31'd0, a}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic a, e;
    logic [31:0] exp_cnt [9] = '{32'd4, 32'd4, 32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd4};

    rst = 1'b1; bus_access = 1'b0; bus_cs = 1'b0; bus_addr = '0;
    bus_wr_val = '0; bus_wr_en = 1'b0; bus_bytesel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, bus_ack}, 32'd0);
    chk("rst_data", bus_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All registers read zero after reset.
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 4; r++) begin
        rd_reg(t, 2'(r), d);
        chk($sformatf("rst_reg_%0d_%0d", t, r), d, 32'd0);
      end
    end
    chk("rst_irq", {28'd0, irq}, 32'd0);

    // Channel 0 one-shot, prescale 0: expiry three cycles after CONTROL write.
    wr_reg(0, R_COUNT, 32'd3, 4'hf);
    wr_reg(0, R_CONTROL, 32'h5, 4'hf);
    repeat (2) @(posedge clk);
    #1;
    chk("c0_irq_early", {28'd0, irq}, 32'h0);
    @(posedge clk);
    #1;
    chk("c0_irq_set", {28'd0, irq}, 32'h1);
    rd_reg(0, R_COUNT, d);
    chk("c0_count", d, 32'd0);
    rd_reg(0, R_CONTROL, d);
    chk("c0_ctrl", d, 32'h4);
    wr_reg(0, R_STATUS, 32'd1, 4'hf);
    chk("c0_irq_clr", {28'd0, irq}, 32'h0);

    // Channel 1 periodic, prescale 1: count steps every 2 cycles, expiry every 8.
    wr_reg(1, R_RELOAD, 32'd4, 4'hf);
    wr_reg(1, R_COUNT, 32'd4, 4'hf);
    wr_reg(1, R_CONTROL, 32'h103, 4'hf);
    for (int n = 0; n < 9; n++) begin
      rd_reg(1, R_COUNT, d);
      chk($sformatf("c1_count_%0d", n + 1), d, exp_cnt[n]);
    end
    rd_reg(1, R_STATUS, d);
    chk("c1_status_exp", d, 32'd1);
    wr_reg(1, R_STATUS, 32'd1, 4'hf);
    rd_reg(1, R_STATUS, d);
    chk("c1_status_clr", d, 32'd0);
    repeat (3) @(posedge clk);
    wr_reg(1, R_STATUS, 32'd1, 4'hf);
    rd_reg(1, R_STATUS, d);
    chk("c1_set_wins", d, 32'd1);
    rd_reg(1, R_COUNT, d);
    chk("c1_reloaded", d, 32'd4);
    chk("c1_irq_masked", {28'd0, irq}, 32'h0);
    wr_reg(1, R_CONTROL, 32'h0, 4'hf);

    // Byte lane enables.
    wr_reg(2, R_RELOAD, 32'hAABBCCDD, 4'b0101);
    rd_reg(2, R_RELOAD, d);
    chk("c2_bytesel", d, 32'h00BB00DD);

    // Unmapped offsets error and leave state untouched.
    bus_xfer(32'h80002100, 1'b1, 32'h12345678, 4'hf, d, a, e);
    chk("inv100_err", {31'd0, e}, 32'd1);
    chk("inv100_ack", {31'd0, a}, 32'd0);
    chk("inv100_data", d, 32'd0);
    @(posedge clk);
    #1;
    chk("inv100_err_drop", {31'd0, bus_error}, 32'd0);
    bus_xfer(32'h80002040, 1'b1, 32'h87654321, 4'hf, d, a, e);
    chk("inv040_err", {31'd0, e}, 32'd1);
    chk("inv040_ack", {31'd0, a}, 32'd0);
    bus_xfer(32'h80002040, 1'b0, 32'd0, 4'hf, d, a, e);
    chk("inv040_rd_err", {31'd0, e}, 32'd1);
    chk("inv040_rd_data", d, 32'd0);
    rd_reg(0, R_COUNT, d);
    chk("inv_no_write", d, 32'd0);

    // Bus write to COUNT beats a concurrent tick.
    wr_reg(3, R_COUNT, 32'h100, 4'hf);
    wr_reg(3, R_CONTROL, 32'h1, 4'hf);
    wr_reg(3, R_COUNT, 32'h10, 4'hf);
    rd_reg(3, R_COUNT, d);
    chk("c3_write_wins", d, 32'h10);
    wr_reg(3, R_CONTROL, 32'h0, 4'hf);

    // One-shot from COUNT=0: EN drops after a single tick, no expiry.
    wr_reg(2, R_CONTROL, 32'h5, 4'hf);
    rd_reg(2, R_CONTROL, d);
    chk("c2_ctrl_en", d, 32'h5);
    rd_reg(2, R_CONTROL, d);
    chk("c2_ctrl_off", d, 32'h4);
    rd_reg(2, R_STATUS, d);
    chk("c2_no_expiry", d, 32'd0);
    chk("c2_irq", {28'd0, irq}, 32'h0);

    // Reset mid-count and mid-access.
    wr_reg(0, R_COUNT, 32'd100, 4'hf);
    wr_reg(0, R_CONTROL, 32'h5, 4'hf);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus_addr = reg_addr(0, R_COUNT); bus_cs = 1'b1; bus_wr_en = 1'b0; bus_access = 1'b1;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ack", {31'd0, bus_ack}, 32'd0);
    chk("rst_mid_data", bus_data, 32'd0);
    chk("rst_mid_irq", {28'd0, irq}, 32'h0);
    bus_access = 1'b0; bus_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd_reg(0, R_COUNT, d);
    chk("rst_mid_count", d, 32'd0);
    rd_reg(0, R_CONTROL, d);
    chk("rst_mid_ctrl", d, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
